// File: rtl/arb_pkg.sv
// Shared types and default widths for the physical-memory arbiter.
package arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_DONE} arb_state_t;
    typedef enum logic {SRC_I, SRC_D} arb_src_t;

    localparam int unsigned ARB_ADDR_W  = 16;
    localparam int unsigned ARB_LINE_W  = 128;
    localparam int unsigned ARB_TIMEOUT = 1023;

endpackage

// File: rtl/pmem_arb_pick.sv
// Combinational winner select between the I-cache and D-cache requesters.
module pmem_arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output arb_src_t grant_c,
    output logic     valid_c
);

    // Contested cycle: D under fixed priority, otherwise whoever was not served last.
    always_comb begin
        grant_c = SRC_I;
        valid_c = i_req | d_req;
        if (i_req && d_req) begin
            if (FIXED_PRIO != 0) begin
                grant_c = SRC_D;
            end else begin
                grant_c = (last_grant == SRC_I) ? SRC_D : SRC_I;
            end
        end else if (d_req) begin
            grant_c = SRC_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one registered physical-memory port between the I-cache and D-cache,
// with a sticky watchdog for transactions that never see pmem_resp.
module pmem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ARB_ADDR_W,
    parameter int unsigned LINE_W     = ARB_LINE_W,
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = ARB_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              err_timeout
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_nxt;
    arb_src_t        owner_q, last_grant_q;
    arb_src_t        pick_grant_c;
    logic            pick_valid_c;
    logic [WD_W-1:0] wd_cnt_q;

    pmem_arb_pick #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant_q),
        .grant_c    (pick_grant_c),
        .valid_c    (pick_valid_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: if (pick_valid_c) state_nxt = ARB_BUSY;
            ARB_BUSY: if (pmem_resp)    state_nxt = ARB_DONE;
            ARB_DONE: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Command, line and response registers; the watchdog counts completed BUSY cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= SRC_I;
            last_grant_q <= SRC_I;
            wd_cnt_q     <= '0;
            err_timeout  <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
        end else begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid_c) begin
                        owner_q      <= pick_grant_c;
                        last_grant_q <= pick_grant_c;
                        wd_cnt_q     <= '0;
                        if (pick_grant_c == SRC_D) begin
                            // A simultaneous read and write-back is treated as a write.
                            pmem_address <= d_address;
                            pmem_wdata   <= d_wdata;
                            pmem_write   <= d_write;
                            pmem_read    <= !d_write;
                        end else begin
                            pmem_address <= i_address;
                            pmem_write   <= 1'b0;
                            pmem_read    <= 1'b1;
                        end
                    end
                end
                ARB_BUSY: begin
                    if (wd_cnt_q != WD_W'(TIMEOUT)) begin
                        wd_cnt_q <= wd_cnt_q + WD_W'(1);
                    end
                    if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                    end
                    if (pmem_resp) begin
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        if (owner_q == SRC_D) begin
                            d_rdata <= pmem_rdata;
                            d_resp  <= 1'b1;
                        end else begin
                            i_rdata <= pmem_rdata;
                            i_resp  <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
